ext_loader: RTL

EXT_LOADER -- requirements
Module: ext_loader

---
 rtl/ext_loader_pkg.sv | 36 +++
 rtl/ext_loader_if.sv | 20 ++
 rtl/ext_loader_byte_serializer.sv | 42 ++++
 rtl/ext_loader.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/ext_loader_pkg.sv
// Shared opcodes, FSM states and decode helpers
// for the host-driven RAM/register loader.
package ext_loader_pkg;

  localparam logic [7:0] OP_INST_WR = 8'h01;
  localparam logic [7:0] OP_DATA_WR = 8'h02;
  localparam logic [7:0] OP_INST_RD = 8'h03;
  localparam logic [7:0] OP_DATA_RD = 8'h04;
  localparam logic [7:0] OP_REG_RD  = 8'h05;
  localparam logic [7:0] OP_CLR_ERR = 8'h06;

  typedef enum logic [2:0] {
    S_OPCODE,
    S_ADDR,
    S_WDATA,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_SEND
  } state_t;

  function automatic logic is_write(
    input logic [7:0] op
  );
    return (op == OP_INST_WR) ||
           (op == OP_DATA_WR);
  endfunction

  // Register reads carry a single address byte.
  function automatic logic [1:0] last_addr(
    input logic [7:0] op
  );
    return (op == OP_REG_RD) ? 2'd0 : 2'd1;
  endfunction

endpackage

// File: rtl/ext_loader_if.sv
// Host byte streams: commands in, responses out,
// each with a valid/ready handshake.
interface ext_loader_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/ext_loader_byte_serializer.sv
// Sends a loaded 32-bit word as four bytes,
// least significant first, over valid/ready.
module byte_serializer (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        done
);

  logic [31:0] sh_q;
  logic [1:0]  cnt_q;
  logic        vld_q;
  logic        fire;

  assign fire = vld_q && out_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sh_q  <= '0;
      cnt_q <= '0;
      vld_q <= 1'b0;
    end else if (load) begin
      sh_q  <= word;
      cnt_q <= '0;
      vld_q <= 1'b1;
    end else if (fire) begin
      // Zero fill leaves out_data at 0 once idle.
      sh_q  <= {8'h00, sh_q[31:8]};
      cnt_q <= cnt_q + 2'd1;
      if (cnt_q == 2'd3) vld_q <= 1'b0;
    end
  end

  assign out_valid = vld_q;
  assign out_data  = sh_q[7:0];
  assign done      = fire && (cnt_q == 2'd3);

endmodule

// File: rtl/ext_loader.sv
// Byte-command loader: writes/reads instruction and
// data RAMs and reads the register bank for a host.
module ext_loader
  import ext_loader_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  ext_loader_if.slave       host,
  output logic [ADDR_W-1:0] inst_ext_address,
  output logic              inst_ext_write,
  output logic [31:0]       inst_ext_in_data,
  input  logic [31:0]       inst_ext_out_data,
  output logic [ADDR_W-1:0] data_ext_address,
  output logic              data_ext_write,
  output logic [31:0]       data_ext_in_data,
  input  logic [31:0]       data_ext_out_data,
  output logic [4:0]        reg_ext_address,
  output logic              reg_ext_read,
  input  logic [31:0]       reg_ext_out_data,
  output logic              busy,
  output logic              error
);

  state_t      state_q, state_d;
  logic [7:0]  op_q;
  logic [15:0] addr_q;
  logic [31:0] wdata_q;
  logic [1:0]  cnt_q;
  logic        err_q;

  logic        in_rdy, fire;
  logic        op_rw, op_clr;
  logic        load, ser_done;
  logic        active, issue;
  logic        inst_sel, data_sel, reg_sel;
  logic [31:0] rd_word;
  logic [ADDR_W-1:0] addr_w;

  assign in_rdy = !reset &&
    (state_q inside {S_OPCODE, S_ADDR, S_WDATA});
  assign fire   = host.in_valid && in_rdy;
  assign op_rw  = host.in_data inside
    {[OP_INST_WR:OP_REG_RD]};
  assign op_clr = host.in_data == OP_CLR_ERR;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      S_OPCODE:
        if (fire) begin
          unique case (1'b1)
            op_rw:   state_d = S_ADDR;
            default: state_d = S_OPCODE;
          endcase
        end
      S_ADDR:
        if (fire && cnt_q == last_addr(op_q))
          state_d = is_write(op_q) ? S_WDATA
                                   : S_ISSUE;
      S_WDATA:
        if (fire && cnt_q == 2'd3)
          state_d = S_ISSUE;
      S_ISSUE:
        state_d = is_write(op_q) ? S_OPCODE
                                 : S_WAIT;
      S_WAIT:
        state_d = S_CAPTURE;
      S_CAPTURE: begin
        load    = 1'b1;
        state_d = S_SEND;
      end
      S_SEND:
        if (ser_done) state_d = S_OPCODE;
      default:
        state_d = S_OPCODE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_OPCODE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q != state_d) cnt_q <= '0;
      else if (fire)          cnt_q <= cnt_q + 2'd1;
      if (fire) begin
        unique case (state_q)
          S_OPCODE: begin
            unique case (1'b1)
              op_rw:   op_q  <= host.in_data;
              op_clr:  err_q <= 1'b0;
              default: err_q <= 1'b1;
            endcase
          end
          S_ADDR:
            addr_q[{cnt_q[0], 3'b000} +: 8]
              <= host.in_data;
          S_WDATA:
            wdata_q[{cnt_q, 3'b000} +: 8]
              <= host.in_data;
          default: ;
        endcase
      end
    end
  end

  assign active = state_q inside
    {S_ISSUE, S_WAIT, S_CAPTURE};
  assign issue  = state_q == S_ISSUE;
  assign addr_w = ADDR_W'(addr_q);

  assign inst_sel = op_q inside {OP_INST_WR, OP_INST_RD};
  assign data_sel = op_q inside {OP_DATA_WR, OP_DATA_RD};
  assign reg_sel  = op_q == OP_REG_RD;

  // Ports stay quiet unless a command is driving them.
  assign inst_ext_address =
    (active && inst_sel) ? addr_w : '0;
  assign data_ext_address =
    (active && data_sel) ? addr_w : '0;
  assign inst_ext_write = issue && op_q == OP_INST_WR;
  assign data_ext_write = issue && op_q == OP_DATA_WR;
  assign inst_ext_in_data =
    inst_ext_write ? wdata_q : '0;
  assign data_ext_in_data =
    data_ext_write ? wdata_q : '0;
  assign reg_ext_read    = active && reg_sel;
  assign reg_ext_address =
    reg_ext_read ? addr_q[4:0] : '0;

  always_comb begin
    rd_word = inst_ext_out_data;
    if (data_sel)     rd_word = data_ext_out_data;
    else if (reg_sel) rd_word = reg_ext_out_data;
  end

  byte_serializer u_ser (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .word      (rd_word),
    .out_valid (host.out_valid),
    .out_ready (host.out_ready),
    .out_data  (host.out_data),
    .done      (ser_done)
  );

  assign host.in_ready = in_rdy;
  assign busy  = state_q != S_OPCODE;
  assign error = err_q;

endmodule
